// File: rtl/regfile_writeback.sv
// Register-file write-port initiator.
// Arbitrates between the single-cycle pipeline result and a 2-entry buffer of
// long-latency results, and tracks which registers still await a long-latency
// write so decode can stall on them.
module regfile_writeback #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pipe_valid,
  input  logic [ADDR_WIDTH-1:0] pipe_rd,
  input  logic [DATA_WIDTH-1:0] pipe_data,
  input  logic                  lu_valid,
  output logic                  lu_ready,
  input  logic [ADDR_WIDTH-1:0] lu_rd,
  input  logic [DATA_WIDTH-1:0] lu_data,
  input  logic                  issue_valid,
  input  logic [ADDR_WIDTH-1:0] issue_rd,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  output logic                  stall,
  output logic                  wb_en,
  output logic [ADDR_WIDTH-1:0] wb_addr,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic [1:0]            fifo_count
);

  localparam int NUM_REGS = 1 << ADDR_WIDTH;

  // Buffer storage; with two entries a single pointer bit addresses it.
  logic [ADDR_WIDTH-1:0] fifo_rd_reg   [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data_reg [FIFO_DEPTH];
  logic                  head_reg;
  logic [1:0]            count_reg;
  logic [NUM_REGS-1:0]   busy_reg;
  logic [NUM_REGS-1:0]   busy_next;

  logic                  push;
  logic                  pop;
  logic                  tail;
  logic [ADDR_WIDTH-1:0] head_rd;
  logic [DATA_WIDTH-1:0] head_data;

  // Readiness looks only at registered occupancy, so a same-cycle pop never
  // opens room early and reset blocks any transfer.
  assign lu_ready   = !rst && (count_reg < 2'd2);
  assign push       = lu_valid && lu_ready;
  // Pop uses the registered count: an entry pushed this edge is not visible yet.
  assign pop        = !pipe_valid && (count_reg != 2'd0);
  assign tail       = head_reg ^ count_reg[0];
  assign head_rd    = fifo_rd_reg[head_reg];
  assign head_data  = fifo_data_reg[head_reg];
  assign fifo_count = count_reg;

  // Decode stall: no bypass of a clear happening this same cycle.
  assign stall = ((rs1 != '0) && busy_reg[rs1]) || ((rs2 != '0) && busy_reg[rs2]);

  // Scoreboard next state: clear on pop first, then set so a newer issue wins.
  always_comb begin
    busy_next = busy_reg;
    if (pop && (head_rd != '0)) begin
      busy_next[head_rd] = 1'b0;
    end
    if (issue_valid && (issue_rd != '0)) begin
      busy_next[issue_rd] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  // Buffer payload storage; contents need no reset since count gates use.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd_reg[tail]   <= lu_rd;
      fifo_data_reg[tail] <= lu_data;
    end
  end

  // Buffer pointers/occupancy and scoreboard state.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg  <= 1'b0;
      count_reg <= 2'd0;
      busy_reg  <= '0;
    end else begin
      if (pop) begin
        head_reg <= ~head_reg;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
      busy_reg <= busy_next;
    end
  end

  // Registered write port: pipeline first, then buffer head, else idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_en   <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
    end else if (pipe_valid) begin
      wb_en   <= (pipe_rd != '0);
      wb_addr <= pipe_rd;
      wb_data <= pipe_data;
    end else if (pop) begin
      wb_en   <= (head_rd != '0);
      wb_addr <= head_rd;
      wb_data <= head_data;
    end else begin
      wb_en   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback: directed scenarios followed by
// random traffic, checked against a queue/array reference model.
module tb_regfile_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_valid;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        stall;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [1:0]  fifo_count;

  regfile_writeback #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .pipe_valid(pipe_valid), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rd(lu_rd), .lu_data(lu_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rs1(rs1), .rs2(rs2), .stall(stall),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // Register file consuming the write port on the falling edge.
  logic [31:0] rf [32];
  initial for (int i = 0; i < 32; i++) rf[i] = 32'h0;
  always @(negedge clk) if (wb_en) rf[wb_addr] <= wb_data;

  // Reference model.
  typedef struct { logic [4:0] rd; logic [31:0] d; } ent_t;
  ent_t        q[$];
  bit          m_busy [32];
  bit          m_en;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic [31:0] m_rf [32];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic idle();
    rst = 0; pipe_valid = 0; pipe_rd = 0; pipe_data = 0;
    lu_valid = 0; lu_rd = 0; lu_data = 0;
    issue_valid = 0; issue_rd = 0; rs1 = 0; rs2 = 0;
  endtask

  // One clock: check combinational outputs, advance the model, check
  // registered outputs, then check the register file after the falling edge.
  task automatic step();
    bit   acc;
    bit   pop;
    bit   exp_stall;
    ent_t e;
    #1;
    exp_stall = (rs1 != 0 && m_busy[rs1]) || (rs2 != 0 && m_busy[rs2]);
    check("lu_ready", {31'b0, lu_ready}, {31'b0, (!rst && q.size() < 2)});
    check("stall", {31'b0, stall}, {31'b0, exp_stall});
    acc = lu_valid && !rst && (q.size() < 2);
    @(posedge clk);
    cyc++;
    if (rst) begin
      q.delete();
      for (int i = 0; i < 32; i++) m_busy[i] = 0;
      m_en = 0; m_addr = 0; m_data = 0;
    end else begin
      pop = !pipe_valid && (q.size() > 0);
      if (pipe_valid) begin
        m_en = (pipe_rd != 0); m_addr = pipe_rd; m_data = pipe_data;
      end else if (pop) begin
        e = q.pop_front();
        m_en = (e.rd != 0); m_addr = e.rd; m_data = e.d;
        if (e.rd != 0) m_busy[e.rd] = 0;
      end else begin
        m_en = 0;
      end
      if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1;
      if (acc) begin
        e.rd = lu_rd; e.d = lu_data;
        q.push_back(e);
      end
    end
    #1;
    check("wb_en", {31'b0, wb_en}, {31'b0, m_en});
    check("wb_addr", {27'b0, wb_addr}, {27'b0, m_addr});
    check("wb_data", wb_data, m_data);
    check("fifo_count", {30'b0, fifo_count}, q.size());
    @(negedge clk);
    if (m_en) m_rf[m_addr] = m_data;
    #1;
    if (m_en) check("rf_write", rf[m_addr], m_rf[m_addr]);
    check("rf_x0", rf[0], 32'h0);
    $display("[TB] cyc %0d rst=%0b pipe=%0b/%0d lu=%0b/%0d acc=%0b wb=%0b x%0d=%0h cnt=%0d stall=%0b",
             cyc, rst, pipe_valid, pipe_rd, lu_valid, lu_rd, acc, wb_en, wb_addr, wb_data,
             fifo_count, stall);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin m_rf[i] = 0; m_busy[i] = 0; end
    m_en = 0; m_addr = 0; m_data = 0;

    // Reset
    idle(); rst = 1;
    step(); step();

    // Pipeline write to x5
    idle(); pipe_valid = 1; pipe_rd = 5; pipe_data = 32'h1234;
    step();
    idle(); step();

    // Long-latency op to x7 with stall tracking
    idle(); issue_valid = 1; issue_rd = 7; rs1 = 7;
    step();
    idle(); rs1 = 7; step();
    idle(); rs1 = 7; lu_valid = 1; lu_rd = 7; lu_data = 32'hAA;
    step();
    idle(); rs1 = 7; step();
    idle(); rs1 = 7; step();

    // Contention: pipeline holds the port while the buffer fills
    idle(); pipe_valid = 1; pipe_rd = 1; pipe_data = 32'h11;
    lu_valid = 1; lu_rd = 3; lu_data = 32'h30; step();
    pipe_rd = 2; pipe_data = 32'h22; lu_rd = 4; lu_data = 32'h40; step();
    pipe_rd = 6; pipe_data = 32'h66; lu_rd = 5; lu_data = 32'h50; step();
    idle(); step(); step(); step();

    // Writes to x0 from both sources
    idle(); pipe_valid = 1; pipe_rd = 0; pipe_data = 32'hDEAD; step();
    idle(); lu_valid = 1; lu_rd = 0; lu_data = 32'hBEEF; step();
    idle(); step(); step();

    // Same-cycle clear and set of x9
    idle(); issue_valid = 1; issue_rd = 9; step();
    idle(); lu_valid = 1; lu_rd = 9; lu_data = 32'h99; rs2 = 9; step();
    idle(); issue_valid = 1; issue_rd = 9; rs2 = 9; step();
    idle(); rs2 = 9; step();
    idle(); lu_valid = 1; lu_rd = 9; lu_data = 32'h9A; rs2 = 9; step();
    idle(); rs2 = 9; step(); step();

    // Reset mid-operation with a full buffer and pending registers
    idle(); issue_valid = 1; issue_rd = 10; step();
    idle(); issue_valid = 1; issue_rd = 11; step();
    idle(); issue_valid = 1; issue_rd = 12; pipe_valid = 1; pipe_rd = 2; pipe_data = 32'h2;
    lu_valid = 1; lu_rd = 10; lu_data = 32'hA0; step();
    idle(); pipe_valid = 1; pipe_rd = 2; pipe_data = 32'h3;
    lu_valid = 1; lu_rd = 11; lu_data = 32'hB0; step();
    idle(); rst = 1; rs1 = 10; rs2 = 11; step();
    idle(); rs1 = 10; rs2 = 12; step(); step(); step();

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      idle();
      rst         = ($urandom_range(0, 99) < 2);
      pipe_valid  = $urandom_range(0, 1);
      pipe_rd     = 5'($urandom_range(0, 31));
      pipe_data   = $urandom;
      lu_valid    = ($urandom_range(0, 2) != 0);
      lu_rd       = 5'($urandom_range(0, 31));
      lu_data     = $urandom;
      issue_valid = ($urandom_range(0, 3) == 0);
      issue_rd    = 5'($urandom_range(0, 31));
      rs1         = 5'($urandom_range(0, 31));
      rs2         = 5'($urandom_range(0, 31));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
- Initiator side of the register-file write port. It produces the per-cycle write enable, destination address and write data that the register file consumes on the falling clock edge.
- It arbitrates between two sources:
  - the single-cycle pipeline result;
  - a long-latency unit result (multi-cycle mul/div/load), buffered in a 2-entry FIFO.
- It keeps a pending-write scoreboard so decode can stall on registers whose long-latency result has not yet been written.

Parameters:
- DATA_WIDTH, 32, width of the write data bus.
- ADDR_WIDTH, 5, register index width (32 architectural registers).
- FIFO_DEPTH, 2, long-latency result buffer entries; must be 2 in this revision.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- pipe_valid  input  1  pipeline result valid this cycle.
- pipe_rd  input  ADDR_WIDTH  pipeline destination register.
- pipe_data  input  DATA_WIDTH  pipeline result.
- lu_valid  input  1  long-latency result offered.
- lu_ready  output  1  FIFO can accept a result; transfer occurs when lu_valid && lu_ready.
- lu_rd  input  ADDR_WIDTH  long-latency destination register.
- lu_data  input  DATA_WIDTH  long-latency result.
- issue_valid  input  1  a long-latency op is dispatched this cycle.
- issue_rd  input  ADDR_WIDTH  its destination register.
- rs1  input  ADDR_WIDTH  decode source register 1 query.
- rs2  input  ADDR_WIDTH  decode source register 2 query.
- stall  output  1  rs1 or rs2 is pending (combinational from the scoreboard register).
- wb_en  output  1  register-file write enable (registered).
- wb_addr  output  ADDR_WIDTH  register-file write address (registered).
- wb_data  output  DATA_WIDTH  register-file write data (registered).
- fifo_count  output  2  current FIFO occupancy, 0..2.

Behaviour:
- Reset (rst high at a rising edge):
  - wb_en=0, wb_addr=0, wb_data=0;
  - FIFO emptied, fifo_count=0;
  - all scoreboard bits cleared.
  - lu_ready is forced to 0 while rst is high, so no transfer is accepted during reset.
  - Reset mid-operation discards buffered results and pending bits without writing them.
- lu_ready = !rst && (fifo_count < 2). It does not depend on lu_valid. It is not raised by a same-cycle pop.
- Arbitration, evaluated every cycle from registered state plus inputs:
  1. If pipe_valid, the pipeline wins: wb_en <= (pipe_rd != 0), wb_addr <= pipe_rd, wb_data <= pipe_data. The FIFO is not popped.
  2. Else if the FIFO is non-empty: pop the head; wb_en <= (head_rd != 0), wb_addr <= head_rd, wb_data <= head_data.
  3. Else wb_en <= 0; wb_addr and wb_data hold their previous values.
- Write latency:
  - Output registers update on the rising edge.
  - The register file samples them on the following falling edge.
  - A pipeline result reaches the register file half a cycle after its rising edge.
- Long-latency FIFO:
  - Strict order.
  - A push and a pop in the same cycle are both honoured; fifo_count is unchanged.
  - A push into an empty FIFO is not eligible for pop in the same cycle; minimum FIFO-to-wb latency is 1 cycle after the push edge.
  - A push when full cannot occur because lu_ready=0. lu_valid while full is held by the source.
- Writes to x0:
  - Never assert wb_en.
  - FIFO entries with rd=0 are still popped.
  - Scoreboard bit 0 is never set.
- Scoreboard (one bit per register):
  - Set on issue_valid with issue_rd != 0.
  - Cleared on the edge where a FIFO pop for that rd is performed.
  - Set and clear of the same register in the same cycle: set wins (a newer op is pending).
  - issue_valid to an already-pending register keeps the bit set. Software ordering guarantees this does not occur; no error flag.
- stall = (rs1 != 0 && busy[rs1]) || (rs2 != 0 && busy[rs2]). There is no bypass of a same-cycle clear.
- fifo_count wraps never: saturating behaviour is guaranteed by lu_ready.

Test Plan:
- Reset, then pipe_valid=1, pipe_rd=5, pipe_data=0x1234 -> next cycle wb_en=1, wb_addr=5, wb_data=0x1234. Register x5 reads 0x1234 after the falling edge.
- issue_valid rd=7 -> stall=1 with rs1=7. Then lu push rd=7, data=0xAA with pipe idle -> wb writes x7=0xAA one cycle after the push edge. stall drops the cycle after the pop edge.
- Contention:
  - Two lu pushes (rd=3/0x30, rd=4/0x40) while pipe_valid is held 3 cycles -> fifo_count=2 and lu_ready=0.
  - A third lu_valid is not accepted.
  - After pipe_valid drops, the writes x3=0x30 then x4=0x40 occur on consecutive cycles.
- pipe_rd=0 or FIFO entry rd=0 -> wb_en=0. The FIFO entry is still popped (fifo_count decrements). x0 is unchanged.
- Same-cycle clear and set:
  - Pending x9 popped in the same cycle as issue_valid rd=9 -> busy[9] remains 1 and stall stays 1 for rs2=9.
- Reset mid-operation:
  - rst with fifo_count=2 and 3 pending bits -> next cycle fifo_count=0, stall=0, wb_en=0.
  - No buffered write ever appears.
